// File: rtl/tmr_sched_pkg.sv
// Shared types and limits for the timer-channel scheduler.
// Imported by tmr_rr_arb and tmr_sched.
package tmr_sched_pkg;

  localparam int TMR_SCHED_MAX_REQ   = 16;
  localparam int TMR_SCHED_CNT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/tmr_rr_arb.sv
// Combinational round-robin arbiter: first set request at or above
// the pointer, wrapping; returns one-hot grant and encoded index.
module tmr_rr_arb
  import tmr_sched_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int OWN_WIDTH = $clog2(NUM_REQ)
) (
  input  logic                 en_i,
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [OWN_WIDTH-1:0] ptr_i,
  output logic [NUM_REQ-1:0]   gnt_o,
  output logic [OWN_WIDTH-1:0] idx_o
);

  localparam logic [OWN_WIDTH:0] L_N = (OWN_WIDTH+1)'(NUM_REQ);

  logic [2*NUM_REQ-1:0] w_rot;
  logic [OWN_WIDTH:0]   w_sum;
  logic                 w_hit;

  // Rotate so bit 0 is the pointer position; first hit wins.
  assign w_rot = {req_i, req_i} >> ptr_i;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    w_hit = 1'b0;
    w_sum = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (en_i && !w_hit && w_rot[i]) begin
        w_hit = 1'b1;
        w_sum = {1'b0, ptr_i} + (OWN_WIDTH+1)'(i);
        if (w_sum >= L_N) w_sum = w_sum - L_N;
        idx_o = w_sum[OWN_WIDTH-1:0];
        gnt_o[w_sum[OWN_WIDTH-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tmr_sched.sv
// Round-robin sharing of one down-counting timer among NUM_REQ clients.
// Optional abort support is enabled with TMR_SCHED_ABORT_EN.
module tmr_sched
  import tmr_sched_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int CNT_WIDTH = TMR_SCHED_CNT_WIDTH,
  parameter int OWN_WIDTH = $clog2(NUM_REQ)
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         en_i,
  input  logic                         clr_i,
  input  logic                         tick_i,
  input  logic [NUM_REQ-1:0]           req_valid_i,
  output logic [NUM_REQ-1:0]           req_ready_o,
  input  logic [NUM_REQ*CNT_WIDTH-1:0] req_dly_i,
  output logic [NUM_REQ-1:0]           done_o,
  output logic                         busy_o,
  output logic [OWN_WIDTH-1:0]         owner_o,
  output logic [CNT_WIDTH-1:0]         cnt_o
`ifdef TMR_SCHED_ABORT_EN
  ,
  input  logic [NUM_REQ-1:0]           abort_i,
  output logic                         aborted_o
`endif
);

  localparam logic [OWN_WIDTH-1:0] L_LAST = OWN_WIDTH'(NUM_REQ - 1);
  localparam logic [CNT_WIDTH-1:0] L_ONE  = CNT_WIDTH'(1);

  state_t               r_state;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [OWN_WIDTH-1:0] r_owner;
  logic [OWN_WIDTH-1:0] r_ptr;

  logic                 w_arb_en;
  logic [NUM_REQ-1:0]   w_gnt;
  logic [OWN_WIDTH-1:0] w_idx;
  logic [CNT_WIDTH-1:0] w_dly;
  logic [NUM_REQ-1:0]   w_own_oh;
  logic                 w_kill;

  assign w_arb_en = en_i && !clr_i && (r_state == IDLE);

  tmr_rr_arb #(
    .NUM_REQ   (NUM_REQ),
    .OWN_WIDTH (OWN_WIDTH)
  ) u_arb (
    .en_i  (w_arb_en),
    .req_i (req_valid_i),
    .ptr_i (r_ptr),
    .gnt_o (w_gnt),
    .idx_o (w_idx)
  );

  assign w_dly    = req_dly_i[w_idx*CNT_WIDTH +: CNT_WIDTH];
  assign w_own_oh = NUM_REQ'(1) << r_owner;

`ifdef TMR_SCHED_ABORT_EN
  logic r_aborted;

  // Abort only counts for the owner of a live job; clear wins.
  assign w_kill = abort_i[r_owner] && (r_state != IDLE) && !clr_i;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) r_aborted <= 1'b0;
    else          r_aborted <= w_kill;
  end

  assign aborted_o = r_aborted;
`else
  assign w_kill = 1'b0;
`endif

  assign req_ready_o = w_gnt;
  assign busy_o      = (r_state != IDLE);
  assign owner_o     = r_owner;
  assign cnt_o       = r_cnt;
  assign done_o      = (r_state == DONE && !clr_i && !w_kill)
                     ? w_own_oh : '0;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_owner <= '0;
      r_ptr   <= '0;
    end else if (clr_i || w_kill) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (|w_gnt) begin
            r_cnt   <= w_dly;
            r_owner <= w_idx;
            r_ptr   <= (w_idx == L_LAST) ? '0 : w_idx + 1'b1;
            r_state <= (w_dly == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (en_i && tick_i && r_cnt != '0) begin
            r_cnt <= r_cnt - L_ONE;
            if (r_cnt == L_ONE) r_state <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/tmr_sched.md
Name: tmr_sched

Overview:
- Round-robin scheduler that shares one down-counting timer channel among N requesters. Each requester submits a one-shot delay expressed in prescaled ticks.
- The block arbitrates between requesters, loads the shared counter and counts it down on the prescaler trigger. When the count expires it returns a done pulse to the owning requester.
- Sits between multiple firmware-visible or hardware timeout clients and the prescaler trigger of the timer core.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- CNT_WIDTH, 32, width of the delay value and of the shared counter.
- OWN_WIDTH, $clog2(NUM_REQ), width of the owner index (derived; not overridden).

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  reset, synchronous, active-low.
- en_i  in  1  scheduler enable; low pauses counting and blocks new grants.
- clr_i  in  1  synchronous soft clear: abandons the current job and returns to IDLE.
- tick_i  in  1  single-cycle prescaled count trigger.
- req_valid_i  in  NUM_REQ  per-requester request valid.
- req_ready_o  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_dly_i  in  NUM_REQ*CNT_WIDTH  flattened delays; requester k uses bits [k*CNT_WIDTH +: CNT_WIDTH].
- done_o  out  NUM_REQ  one-cycle expiry pulse to the owner.
- busy_o  out  1  high whenever state is not IDLE.
- owner_o  out  OWN_WIDTH  index of the current owner.
- cnt_o  out  CNT_WIDTH  remaining ticks.

Behaviour:
- Reset (rst_n_i low at a clk_i edge): state IDLE, counter 0, owner 0, round-robin pointer 0, done_o 0, busy_o 0. req_ready_o is combinational and is therefore 0 in IDLE while no request is valid.
- States: IDLE, RUN, DONE.
- IDLE:
  - When en_i=1 and any req_valid_i is set, the arbiter selects the first valid index k, searching from the pointer upward with wrap.
  - req_ready_o[k]=1 combinationally in that cycle; the handshake completes at that edge.
  - Next state: counter=req_dly_i[k], owner=k, pointer=(k+1) mod NUM_REQ.
  - Next state is RUN if the delay is non-zero, DONE if the delay is zero.
- RUN:
  - tick_i=1 with en_i=1: counter decrements.
  - A tick while the counter is 1: counter becomes 0 and state moves to DONE.
  - en_i=0: counter and state hold; ticks are lost.
  - req_ready_o is all zero in RUN.
- DONE: done_o[owner]=1 for exactly one cycle, then IDLE. No request is accepted in DONE.
- Latency:
  - done_o asserts on the cycle after the edge that sampled the DLY-th qualifying tick.
  - A delay of 0 gives done_o one cycle after acceptance.
  - Minimum spacing from one acceptance to the next is 3 cycles (accept, DONE, IDLE).
- tick_i is ignored in IDLE and DONE.
- clr_i has priority over everything except reset:
  - next state IDLE, counter 0, no done pulse, pointer unchanged;
  - req_ready_o is forced to 0 while clr_i=1.
- Requester k must hold req_valid_i and req_dly_i stable until accepted; deasserting before acceptance is legal and withdraws the request.
- A requester may re-request immediately after its done pulse; round-robin still favours the other pending requesters.
- The counter never wraps: decrement occurs only while the counter is at least 1.

Optional Feature:
- Macro: TMR_SCHED_ABORT_EN.
- Defined:
  - Adds port abort_i  in  NUM_REQ and port aborted_o  out  1.
  - abort_i[owner]=1 in RUN or DONE sends the next state to IDLE with counter 0, suppresses done_o, and pulses aborted_o for one cycle.
  - abort_i for a non-owner is ignored.
  - clr_i takes precedence over abort_i; clr_i does not pulse aborted_o.
- Undefined: neither port exists; jobs always run to completion or to clr_i.

Decomposition:
- Package tmr_sched_pkg holds:
  - the state typedef enum {IDLE, RUN, DONE} (2 bits);
  - constants TMR_SCHED_MAX_REQ=16 and TMR_SCHED_CNT_WIDTH=32.
- Sub-module tmr_rr_arb (NUM_REQ):
  - inputs: req vector, pointer, enable;
  - outputs: one-hot grant and encoded index;
  - purely combinational; reused by future multi-channel blocks.
- Counter, FSM and pointer update are in tmr_sched.

Test Plan:
- Single job: requester 2 with delay 5 and tick every 4 cycles -> req_ready_o=4'b0100 on acceptance; done_o=4'b0100 one cycle after the 5th tick; busy_o falls the following cycle.
- Fairness: all 4 requesters continuously valid with delay 1 -> grants in order 0,1,2,3,0; owner_o follows the same order.
- Zero delay: requester 1 with delay 0 and no ticks -> done_o[1] one cycle after acceptance; cnt_o=0 throughout.
- Pause: delay 3 with en_i low after the 1st tick for 10 cycles (ticks still arriving) -> cnt_o holds at 2; done_o comes only after 2 further ticks once en_i is high.
- Clear mid-job: delay 100 with clr_i pulsed after tick 10 -> IDLE next cycle, no done_o, pointer unchanged; the next grant obeys round-robin order.
- Abort (TMR_SCHED_ABORT_EN defined): owner 3 asserts abort_i[3] in RUN -> aborted_o pulses once, done_o stays 0. With the macro undefined, the bench checks that neither port exists.
